mem_client_port: RTL

//  Core-side initiator for the shared-RAM arbiter; one instance per core.
//  - Accepts load/store commands from the core datapath.
//  - Drives that core's rden/wren bit plus its 8-bit Address/Din slice.
//  - Waits for the acq grant, issues beats and captures read bytes off the Dq slice.
//  - Returns each read byte to the core.
//  - Reads may be bursts of incrementing addresses. Writes are always single-byte.

---
 rtl/mem_if_pkg.sv | 15 +
 rtl/mem_tag_pipe.sv | 35 +++
 rtl/mem_client_port.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, latency default and port FSM states for the shared-RAM client
package mem_if_pkg;

   localparam int DATA_W       = 8;
   localparam int ADDR_W       = 8;
   localparam int READ_LAT_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/mem_tag_pipe.sv
// rtl/mem_tag_pipe.sv - fixed-depth {valid, last} shift register tracking reads in flight
module mem_tag_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_valid_i,
   input  logic push_last_i,
   output logic out_valid_o,
   output logic out_last_o,
   output logic empty_o
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         valid_q[0] <= push_valid_i;
         last_q[0]  <= push_valid_i & push_last_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            last_q[i]  <= last_q[i-1];
         end
      end
   end

   assign out_valid_o = valid_q[DEPTH-1];
   assign out_last_o  = last_q[DEPTH-1];
   assign empty_o     = ~|valid_q;

endmodule

// File: rtl/mem_client_port.sv
// rtl/mem_client_port.sv - per-core load/store initiator toward the shared-RAM arbiter
module mem_client_port
   import mem_if_pkg::*;
#(
   parameter int READ_LAT  = READ_LAT_DEF,
   parameter int MAX_BURST = 8,
   parameter int LEN_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_last,
   output logic              rden,
   output logic              wren,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] din_o,
   input  logic              acq,
   input  logic [DATA_W-1:0] dq_i
);

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] rdata_q;
   logic [LEN_W-1:0]  beats_q;
   logic [LEN_W-1:0]  len_clamped;
   logic              rden_q;
   logic              wren_q;
   logic              cmd_ready_q;
   logic              resp_valid_q;
   logic              resp_last_q;
   logic              issue;
   logic              tag_valid;
   logic              tag_last;
   logic              tag_empty;

   always_comb begin
      len_clamped = cmd_len;
      if (cmd_len == '0) begin
         len_clamped = LEN_W'(1);
      end else if (cmd_len > LEN_W'(MAX_BURST)) begin
         len_clamped = LEN_W'(MAX_BURST);
      end
   end

   assign issue = rden_q && acq && (state_q == ST_REQ || state_q == ST_ISSUE);

   mem_tag_pipe #(
      .DEPTH (READ_LAT)
   ) u_tag_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_valid_i (issue),
      .push_last_i  (beats_q == LEN_W'(1)),
      .out_valid_o  (tag_valid),
      .out_last_o   (tag_last),
      .empty_o      (tag_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         din_q        <= '0;
         rdata_q      <= '0;
         beats_q      <= '0;
         rden_q       <= 1'b0;
         wren_q       <= 1'b0;
         cmd_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
      end else begin
         resp_valid_q <= tag_valid;
         resp_last_q  <= tag_last;
         if (tag_valid) begin
            rdata_q <= dq_i;
         end
         case (state_q)
            ST_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  addr_q      <= cmd_addr;
                  din_q       <= cmd_we ? cmd_wdata : '0;
                  beats_q     <= cmd_we ? LEN_W'(1) : len_clamped;
                  rden_q      <= !cmd_we;
                  wren_q      <= cmd_we;
                  cmd_ready_q <= 1'b0;
                  state_q     <= ST_REQ;
               end
            end
            ST_REQ, ST_ISSUE: begin
               if (acq && wren_q) begin
                  // Completion passes through DRAIN so the response cycle never overlaps an accept.
                  wren_q       <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_last_q  <= 1'b1;
                  state_q      <= ST_DRAIN;
               end else if (issue) begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  beats_q <= beats_q - LEN_W'(1);
                  if (beats_q == LEN_W'(1)) begin
                     rden_q  <= 1'b0;
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q <= ST_ISSUE;
                  end
               end
            end
            ST_DRAIN: begin
               if (tag_empty) begin
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rden       = rden_q;
   assign wren       = wren_q;
   assign addr_o     = addr_q;
   assign din_o      = din_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_last  = resp_last_q;

endmodule
